riscv_lsu_handshake: RTL and testbench

- Parametrised load/store unit. Successor to the combinational dmem interface: the pipelined core is no longer tied to a single-cycle data memory.
- Sits between the pipeline MEM stage and a req/gnt/rvalid data bus.
- Converts byte, half and word accesses into word-aligned bus transfers with byte lanes, and extends load data to XLEN.
- Stalls the pipeline while a transfer is in flight. Reports misalignment, bus errors and timeouts.

---
 rtl/riscv_lsu_handshake.sv | 188 ++++++++++++++++++
 tb/tb_riscv_lsu_handshake.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_lsu_handshake.sv
// Load/store unit: turns MEM-stage byte/half/word accesses into word-aligned req/gnt/rvalid bus transfers.
// Latency: store >= 2 stall cycles (IDLE, REQ) then DONE; load >= IDLE, REQ, RESP, DONE.
// Backpressure: bus_req is held with stable fields until gnt; the pipeline is stalled through REQ/RESP.
//
// Ports:
//   i_clk, i_rstn              clock, async active-low reset
//   i_lsu_*                    MEM-stage request (valid, wr_en, func3, addr, wr_data)
//   o_lsu_rd_data/rd_valid     registered, extended load result and its one-cycle pulse
//   o_lsu_stall                hold the pipeline
//   o_lsu_exc / o_lsu_err      misaligned/illegal pulse; bus error or timeout pulse
//   o_lsu_bus_* / i_lsu_bus_*  req/gnt/rvalid data bus
module riscv_lsu_handshake #(
  parameter int XLEN        = 32,  // only 32 is supported
  parameter int TIMEOUT_CYC = 16,  // 0 disables the timeout
  parameter int CNT_W       = 5    // 2**CNT_W must exceed TIMEOUT_CYC
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_lsu_valid,
  input  logic            i_lsu_wr_en,
  input  logic [2:0]      i_lsu_func3,
  input  logic [XLEN-1:0] i_lsu_addr,
  input  logic [XLEN-1:0] i_lsu_wr_data,
  output logic [XLEN-1:0] o_lsu_rd_data,
  output logic            o_lsu_rd_valid,
  output logic            o_lsu_stall,
  output logic            o_lsu_exc,
  output logic            o_lsu_err,
  output logic            o_lsu_bus_req,
  output logic [XLEN-1:0] o_lsu_bus_addr,
  output logic            o_lsu_bus_wen,
  output logic [3:0]      o_lsu_bus_byte_sel,
  output logic [XLEN-1:0] o_lsu_bus_wr_data,
  input  logic            i_lsu_bus_gnt,
  input  logic            i_lsu_bus_rvalid,
  input  logic [XLEN-1:0] i_lsu_bus_rdata,
  input  logic            i_lsu_bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              op_wr_q;
  logic [2:0]        op_f3_q;
  logic [XLEN-1:0]   op_addr_q;
  logic [XLEN-1:0]   op_wd_q;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   rd_data_q;

  logic              legal;
  logic              accept;
  logic              timeout_hit;
  logic [3:0]        sel;
  logic [XLEN-1:0]   wdat;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   ext;

  // Legality of the access presented by the MEM stage.
  always_comb begin
    legal = 1'b0;
    case (i_lsu_func3)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~i_lsu_addr[0];
      3'b010:  legal = (i_lsu_addr[1:0] == 2'b00);
      3'b100:  legal = ~i_lsu_wr_en;
      3'b101:  legal = ~i_lsu_wr_en & ~i_lsu_addr[0];
      default: legal = 1'b0;
    endcase
  end

  assign accept = (state_q == S_IDLE) && i_lsu_valid && legal;

  // Timeout fires on the last allowed REQ/RESP cycle; a completion in that
  // same cycle still takes priority (except a load gnt, which is not completion).
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Byte lanes and lane-replicated store data from the latched op.
  always_comb begin
    sel  = 4'b1111;
    wdat = op_wd_q;
    case (op_f3_q[1:0])
      2'b00: begin
        sel  = 4'b0001 << op_addr_q[1:0];
        wdat = {4{op_wd_q[7:0]}};
      end
      2'b01: begin
        sel  = 4'b0011 << {op_addr_q[1], 1'b0};
        wdat = {2{op_wd_q[15:0]}};
      end
      default: ;
    endcase
  end

  // Bring the addressed lane down to bit 0, then extend.
  assign shifted = i_lsu_bus_rdata >> {op_addr_q[1:0], 3'b000};

  always_comb begin
    ext = shifted;
    case (op_f3_q)
      3'b000:  ext = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
      3'b001:  ext = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      3'b100:  ext = {{(XLEN-8){1'b0}},         shifted[7:0]};
      3'b101:  ext = {{(XLEN-16){1'b0}},        shifted[15:0]};
      default: ext = shifted;
    endcase
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_REQ;
          err_d   = 1'b0;
        end
      end
      S_REQ: begin
        if (i_lsu_bus_gnt && op_wr_q) begin
          // A store is done once granted; err sampled with gnt wins.
          state_d = S_DONE;
          err_d   = i_lsu_bus_err;
        end else if (timeout_hit) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else if (i_lsu_bus_gnt) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (i_lsu_bus_rvalid) begin
          state_d = S_DONE;
          err_d   = i_lsu_bus_err;
        end else if (timeout_hit) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= S_IDLE;
      op_wr_q   <= 1'b0;
      op_f3_q   <= 3'b000;
      op_addr_q <= '0;
      op_wd_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (accept) begin
        op_wr_q   <= i_lsu_wr_en;
        op_f3_q   <= i_lsu_func3;
        op_addr_q <= i_lsu_addr;
        op_wd_q   <= i_lsu_wr_data;
        cnt_q     <= '0;
      end else if (state_q == S_REQ || state_q == S_RESP) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      // Errored responses leave the previous load result in place.
      if (state_q == S_RESP && i_lsu_bus_rvalid && !i_lsu_bus_err) begin
        rd_data_q <= ext;
      end
    end
  end

  // Combinational outputs are gated by reset so every output reads 0 while
  // i_rstn is low, even if the MEM stage keeps presenting a request.
  assign o_lsu_stall        = i_rstn && ((state_q == S_REQ) || (state_q == S_RESP) || accept);
  assign o_lsu_exc          = i_rstn && (state_q == S_IDLE) && i_lsu_valid && !legal;
  assign o_lsu_rd_valid     = (state_q == S_DONE) && !op_wr_q && !err_q;
  assign o_lsu_err          = (state_q == S_DONE) && err_q;
  assign o_lsu_rd_data      = rd_data_q;
  assign o_lsu_bus_req      = (state_q == S_REQ);
  assign o_lsu_bus_addr     = o_lsu_bus_req ? {op_addr_q[XLEN-1:2], 2'b00} : '0;
  assign o_lsu_bus_wen      = o_lsu_bus_req && op_wr_q;
  assign o_lsu_bus_byte_sel = o_lsu_bus_req ? sel : 4'b0000;
  assign o_lsu_bus_wr_data  = (o_lsu_bus_req && op_wr_q) ? wdat : '0;

endmodule

// File: tb/tb_riscv_lsu_handshake.sv
// Directed bench for riscv_lsu_handshake: stores, extended loads, illegal
// accesses, timeout, bus error, back-to-back ops and reset mid-transfer.
// Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_riscv_lsu_handshake;

  logic        i_clk;
  logic        i_rstn;
  logic        i_lsu_valid;
  logic        i_lsu_wr_en;
  logic [2:0]  i_lsu_func3;
  logic [31:0] i_lsu_addr;
  logic [31:0] i_lsu_wr_data;
  logic [31:0] o_lsu_rd_data;
  logic        o_lsu_rd_valid;
  logic        o_lsu_stall;
  logic        o_lsu_exc;
  logic        o_lsu_err;
  logic        o_lsu_bus_req;
  logic [31:0] o_lsu_bus_addr;
  logic        o_lsu_bus_wen;
  logic [3:0]  o_lsu_bus_byte_sel;
  logic [31:0] o_lsu_bus_wr_data;
  logic        i_lsu_bus_gnt;
  logic        i_lsu_bus_rvalid;
  logic [31:0] i_lsu_bus_rdata;
  logic        i_lsu_bus_err;

  int n_tests = 0;
  int n_fail  = 0;

  riscv_lsu_handshake #(.XLEN(32), .TIMEOUT_CYC(16), .CNT_W(5)) dut (
    .i_clk              (i_clk),
    .i_rstn             (i_rstn),
    .i_lsu_valid        (i_lsu_valid),
    .i_lsu_wr_en        (i_lsu_wr_en),
    .i_lsu_func3        (i_lsu_func3),
    .i_lsu_addr         (i_lsu_addr),
    .i_lsu_wr_data      (i_lsu_wr_data),
    .o_lsu_rd_data      (o_lsu_rd_data),
    .o_lsu_rd_valid     (o_lsu_rd_valid),
    .o_lsu_stall        (o_lsu_stall),
    .o_lsu_exc          (o_lsu_exc),
    .o_lsu_err          (o_lsu_err),
    .o_lsu_bus_req      (o_lsu_bus_req),
    .o_lsu_bus_addr     (o_lsu_bus_addr),
    .o_lsu_bus_wen      (o_lsu_bus_wen),
    .o_lsu_bus_byte_sel (o_lsu_bus_byte_sel),
    .o_lsu_bus_wr_data  (o_lsu_bus_wr_data),
    .i_lsu_bus_gnt      (i_lsu_bus_gnt),
    .i_lsu_bus_rvalid   (i_lsu_bus_rvalid),
    .i_lsu_bus_rdata    (i_lsu_bus_rdata),
    .i_lsu_bus_err      (i_lsu_bus_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Load from IDLE: gnt in REQ cycle (gnt_wait+1), rvalid the cycle after gnt.
  task automatic load_txn(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input int gnt_wait, input logic [31:0] rdata, input logic berr,
                          input logic [31:0] exp_data, input logic exp_vld);
    i_lsu_valid = 1'b1; i_lsu_wr_en = 1'b0; i_lsu_func3 = f3; i_lsu_addr = addr;
    #1;
    chk({tag, ".stall_idle"}, {31'd0, o_lsu_stall}, 32'd1);
    tick();
    chk({tag, ".req"}, {31'd0, o_lsu_bus_req}, 32'd1);
    chk({tag, ".bus_addr"}, o_lsu_bus_addr, {addr[31:2], 2'b00});
    repeat (gnt_wait) tick();
    i_lsu_bus_gnt = 1'b1;
    tick();
    i_lsu_bus_gnt = 1'b0;
    chk({tag, ".resp_req"}, {31'd0, o_lsu_bus_req}, 32'd0);
    i_lsu_bus_rvalid = 1'b1; i_lsu_bus_rdata = rdata; i_lsu_bus_err = berr;
    tick();
    i_lsu_bus_rvalid = 1'b0; i_lsu_bus_rdata = 32'h0; i_lsu_bus_err = 1'b0;
    chk({tag, ".rd_valid"}, {31'd0, o_lsu_rd_valid}, {31'd0, exp_vld});
    chk({tag, ".err"}, {31'd0, o_lsu_err}, {31'd0, berr});
    chk({tag, ".rd_data"}, o_lsu_rd_data, exp_data);
    chk({tag, ".stall_done"}, {31'd0, o_lsu_stall}, 32'd0);
    i_lsu_valid = 1'b0;
    tick();
    chk({tag, ".rd_valid_pulse"}, {31'd0, o_lsu_rd_valid}, 32'd0);
  endtask

  initial begin
    int k;
    logic [31:0] last_rd;

    i_rstn = 1'b0; i_lsu_valid = 1'b0; i_lsu_wr_en = 1'b0; i_lsu_func3 = 3'b000;
    i_lsu_addr = 32'h0; i_lsu_wr_data = 32'h0; i_lsu_bus_gnt = 1'b0;
    i_lsu_bus_rvalid = 1'b0; i_lsu_bus_rdata = 32'h0; i_lsu_bus_err = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst.req",      {31'd0, o_lsu_bus_req},   32'd0);
    chk("rst.stall",    {31'd0, o_lsu_stall},     32'd0);
    chk("rst.rd_valid", {31'd0, o_lsu_rd_valid},  32'd0);
    chk("rst.err",      {31'd0, o_lsu_err},       32'd0);
    chk("rst.rd_data",  o_lsu_rd_data,            32'h0);
    chk("rst.bus_addr", o_lsu_bus_addr,           32'h0);
    i_rstn = 1'b1;
    tick();

    // SB 0x1003 <- 0xA5, gnt in the first REQ cycle
    i_lsu_valid = 1'b1; i_lsu_wr_en = 1'b1; i_lsu_func3 = 3'b000;
    i_lsu_addr = 32'h0000_1003; i_lsu_wr_data = 32'h0000_00A5;
    #1;
    chk("sb.stall_idle", {31'd0, o_lsu_stall}, 32'd1);
    chk("sb.req_idle",   {31'd0, o_lsu_bus_req}, 32'd0);
    tick();
    i_lsu_bus_gnt = 1'b1;
    chk("sb.req",      {31'd0, o_lsu_bus_req}, 32'd1);
    chk("sb.bus_addr", o_lsu_bus_addr, 32'h0000_1000);
    chk("sb.byte_sel", {28'd0, o_lsu_bus_byte_sel}, 32'h8);
    chk("sb.wr_data",  o_lsu_bus_wr_data, 32'hA5A5_A5A5);
    chk("sb.wen",      {31'd0, o_lsu_bus_wen}, 32'd1);
    chk("sb.stall_req", {31'd0, o_lsu_stall}, 32'd1);
    tick();
    i_lsu_bus_gnt = 1'b0;
    chk("sb.stall_done", {31'd0, o_lsu_stall}, 32'd0);
    chk("sb.rd_valid",   {31'd0, o_lsu_rd_valid}, 32'd0);
    chk("sb.err",        {31'd0, o_lsu_err}, 32'd0);
    chk("sb.req_done",   {31'd0, o_lsu_bus_req}, 32'd0);
    i_lsu_valid = 1'b0;
    tick();

    // Extended loads
    load_txn("lb",  3'b000, 32'h0000_2002, 2, 32'h0080_0000, 1'b0, 32'hFFFF_FF80, 1'b1);
    load_txn("lbu", 3'b100, 32'h0000_2002, 2, 32'h0080_0000, 1'b0, 32'h0000_0080, 1'b1);
    load_txn("lh",  3'b001, 32'h0000_3002, 0, 32'h8001_0000, 1'b0, 32'hFFFF_8001, 1'b1);
    load_txn("lhu", 3'b101, 32'h0000_3002, 1, 32'h8001_0000, 1'b0, 32'h0000_8001, 1'b1);
    last_rd = 32'h0000_8001;

    // Illegal: misaligned LW
    i_lsu_valid = 1'b1; i_lsu_wr_en = 1'b0; i_lsu_func3 = 3'b010; i_lsu_addr = 32'h0000_3001;
    #1;
    chk("lw_mis.exc",   {31'd0, o_lsu_exc},   32'd1);
    chk("lw_mis.stall", {31'd0, o_lsu_stall}, 32'd0);
    tick();
    chk("lw_mis.req",   {31'd0, o_lsu_bus_req}, 32'd0);
    // Illegal: store with func3 100, and reserved func3 011
    i_lsu_wr_en = 1'b1; i_lsu_func3 = 3'b100; i_lsu_addr = 32'h0000_3000;
    #1;
    chk("sbu.exc", {31'd0, o_lsu_exc}, 32'd1);
    i_lsu_wr_en = 1'b0; i_lsu_func3 = 3'b011;
    #1;
    chk("f3_011.exc", {31'd0, o_lsu_exc}, 32'd1);
    i_lsu_valid = 1'b0;
    #1;
    chk("exc_clear", {31'd0, o_lsu_exc}, 32'd0);
    tick();
    chk("illegal.req", {31'd0, o_lsu_bus_req}, 32'd0);

    // Timeout: LW granted, no rvalid
    i_lsu_valid = 1'b1; i_lsu_wr_en = 1'b0; i_lsu_func3 = 3'b010; i_lsu_addr = 32'h0000_4000;
    tick();
    i_lsu_bus_gnt = 1'b1;
    k = 0;
    while (!o_lsu_err && k < 40) begin
      tick();
      i_lsu_bus_gnt = 1'b0;
      k++;
    end
    chk("to.cycles",   k, 32'd16);
    chk("to.rd_valid", {31'd0, o_lsu_rd_valid}, 32'd0);
    chk("to.rd_data",  o_lsu_rd_data, last_rd);
    i_lsu_valid = 1'b0;
    tick();
    chk("to.idle_stall", {31'd0, o_lsu_stall}, 32'd0);
    // Late rvalid in IDLE is ignored
    i_lsu_bus_rvalid = 1'b1; i_lsu_bus_rdata = 32'hDEAD_BEEF;
    tick();
    i_lsu_bus_rvalid = 1'b0;
    chk("late.rd_valid", {31'd0, o_lsu_rd_valid}, 32'd0);
    chk("late.rd_data",  o_lsu_rd_data, last_rd);
    tick();

    // LW with rvalid+err: no rd_valid, data unchanged
    load_txn("lw_err", 3'b010, 32'h0000_4004, 0, 32'h1234_5678, 1'b1, last_rd, 1'b0);

    // Back-to-back SW then LW with valid held
    i_lsu_valid = 1'b1; i_lsu_wr_en = 1'b1; i_lsu_func3 = 3'b010;
    i_lsu_addr = 32'h0000_5000; i_lsu_wr_data = 32'h1234_5678;
    tick();
    i_lsu_bus_gnt = 1'b1;
    chk("sw.wr_data",  o_lsu_bus_wr_data, 32'h1234_5678);
    chk("sw.byte_sel", {28'd0, o_lsu_bus_byte_sel}, 32'hF);
    tick();
    i_lsu_bus_gnt = 1'b0;
    chk("sw.stall_done", {31'd0, o_lsu_stall}, 32'd0);
    i_lsu_wr_en = 1'b0; i_lsu_addr = 32'h0000_5004;
    tick();
    chk("b2b.idle_req",   {31'd0, o_lsu_bus_req}, 32'd0);
    chk("b2b.idle_stall", {31'd0, o_lsu_stall}, 32'd1);
    tick();
    chk("b2b.req",      {31'd0, o_lsu_bus_req}, 32'd1);
    chk("b2b.bus_addr", o_lsu_bus_addr, 32'h0000_5004);
    chk("b2b.wen",      {31'd0, o_lsu_bus_wen}, 32'd0);
    i_lsu_bus_gnt = 1'b1;
    tick();
    i_lsu_bus_gnt = 1'b0;
    i_lsu_bus_rvalid = 1'b1; i_lsu_bus_rdata = 32'hCAFE_BABE;
    tick();
    i_lsu_bus_rvalid = 1'b0;
    chk("b2b.rd_valid", {31'd0, o_lsu_rd_valid}, 32'd1);
    chk("b2b.rd_data",  o_lsu_rd_data, 32'hCAFE_BABE);
    i_lsu_valid = 1'b0;
    tick();

    // Reset asserted while in RESP
    i_lsu_valid = 1'b1; i_lsu_wr_en = 1'b0; i_lsu_func3 = 3'b010; i_lsu_addr = 32'h0000_6000;
    tick();
    i_lsu_bus_gnt = 1'b1;
    tick();
    i_lsu_bus_gnt = 1'b0;
    chk("rr.stall_resp", {31'd0, o_lsu_stall}, 32'd1);
    #2;
    i_rstn = 1'b0;
    #1;
    chk("rr.stall",    {31'd0, o_lsu_stall},    32'd0);
    chk("rr.req",      {31'd0, o_lsu_bus_req},  32'd0);
    chk("rr.rd_valid", {31'd0, o_lsu_rd_valid}, 32'd0);
    i_lsu_valid = 1'b0;
    tick();
    i_rstn = 1'b1;
    i_lsu_bus_rvalid = 1'b1; i_lsu_bus_rdata = 32'h1111_1111;
    tick();
    i_lsu_bus_rvalid = 1'b0;
    chk("rr.late_rd_valid", {31'd0, o_lsu_rd_valid}, 32'd0);
    tick();
    chk("rr.late_rd_valid2", {31'd0, o_lsu_rd_valid}, 32'd0);
    chk("rr.rd_data",        o_lsu_rd_data, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
